// File: rtl/kda_pkg.sv
// kda_pkg: shared types and constants for the KDA job scheduler.
//   kda_sched_state_e : scheduler FSM states (IDLE, RUN, FLUSH)
//   KDA_HASH_W        : default width of one pbkdf2 lane result
//   KDA_DATA_W        : default width of one output stream word
//   words_per_hash()  : number of output words emitted per lane result
package kda_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } kda_sched_state_e;

  localparam int KDA_HASH_W = 256;
  localparam int KDA_DATA_W = 64;

  // hash_w is expected to be an exact multiple of data_w.
  function automatic int words_per_hash(input int hash_w, input int data_w);
    return hash_w / data_w;
  endfunction

endpackage

// File: rtl/kda_sched_serializer.sv
// kda_sched_serializer: holds one lane hash and emits it as HASH_W/DATA_W
// words, most significant word first, on a valid/yumi stream.
//   clk_i, reset_i : clock, synchronous active-high reset
//   load_v_i       : capture load_hash_i (only while load_ready_o is high)
//   load_hash_i    : hash to serialise
//   load_last_i    : the loaded hash is the final block of the job
//   load_ready_o   : empty, or the final word is being consumed this cycle
//   data_o, v_o    : output word and valid (data_o holds until yumi_i)
//   last_o         : final word of the final block
//   yumi_i         : downstream consumed the word (ignored while v_o=0)
module kda_sched_serializer
  import kda_pkg::*;
#(
  parameter int HASH_W = KDA_HASH_W,
  parameter int DATA_W = KDA_DATA_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_v_i,
  input  logic [HASH_W-1:0] load_hash_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              v_o,
  output logic              last_o,
  input  logic              yumi_i
);

  localparam int WORDS = words_per_hash(HASH_W, DATA_W);
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WORDS - 1);

  logic [HASH_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_v;
  logic              r_last_blk;

  logic w_tc;
  logic w_final_yumi;

  // Words remaining is a down-counter; terminal count marks the final word.
  assign w_tc         = (r_cnt == '0);
  assign w_final_yumi = r_v & yumi_i & w_tc;
  assign load_ready_o = ~r_v | w_final_yumi;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_v        <= 1'b0;
      r_last_blk <= 1'b0;
    end else if (load_v_i) begin
      // A load on the same edge as the final yumi gives back-to-back blocks.
      r_shift    <= load_hash_i;
      r_cnt      <= CNT_START;
      r_v        <= 1'b1;
      r_last_blk <= load_last_i;
    end else if (r_v & yumi_i) begin
      // Shifting zeros in leaves data_o at 0 once the hash is drained.
      r_shift <= r_shift << DATA_W;
      if (w_tc) begin
        r_v        <= 1'b0;
        r_last_blk <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign data_o = r_shift[HASH_W-1 -: DATA_W];
  assign v_o    = r_v;
  assign last_o = r_v & r_last_blk & w_tc;

endmodule

// File: rtl/kda_sched.sv
// kda_sched: fans PBKDF2 block indices 1..N out to NUM_LANES pbkdf2 lanes in
// rounds, collects the lane hashes strictly in block order and serialises
// them onto a DATA_W valid/yumi stream.
//   clk_i, reset_i     : clock, synchronous active-high reset
//   req_v_i/req_ready_o: job request handshake (ready only in IDLE)
//   blocks_i           : requested block count, 0 is treated as 1
//   lane_v_o/lane_ready_i : per-lane issue handshake
//   lane_idx_o         : block index, replicated on every lane slice
//   lane_done_v_i/lane_hash_i/lane_yumi_o : per-lane result handshake
//   data_o/v_o/last_o/yumi_i : output word stream
//   cycles_o           : job cycle count
// Build option: define KDA_SCHED_PERF_EN to build the cycles_o counter;
// otherwise cycles_o is tied to 0.
//
// state | meaning
// IDLE  | waiting for a request, req_ready_o high
// RUN   | issuing blocks to lanes and collecting hashes in order
// FLUSH | all hashes collected, waiting for the final word's yumi
module kda_sched
  import kda_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int BLOCKS_W  = 4,
  parameter int DATA_W    = KDA_DATA_W,
  parameter int HASH_W    = KDA_HASH_W
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          req_v_i,
  output logic                          req_ready_o,
  input  logic [BLOCKS_W-1:0]           blocks_i,
  output logic [NUM_LANES-1:0]          lane_v_o,
  input  logic [NUM_LANES-1:0]          lane_ready_i,
  output logic [NUM_LANES*BLOCKS_W-1:0] lane_idx_o,
  input  logic [NUM_LANES-1:0]          lane_done_v_i,
  input  logic [NUM_LANES*HASH_W-1:0]   lane_hash_i,
  output logic [NUM_LANES-1:0]          lane_yumi_o,
  output logic [DATA_W-1:0]             data_o,
  output logic                          v_o,
  output logic                          last_o,
  input  logic                          yumi_i,
  output logic [31:0]                   cycles_o
);

  // One extra bit so that issue_idx can reach total+1 without wrapping.
  localparam int IDX_W  = BLOCKS_W + 1;
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  kda_sched_state_e     r_state;
  logic                 r_req_ready;
  logic [IDX_W-1:0]     r_total;
  logic [IDX_W-1:0]     r_issue_idx;
  logic [IDX_W-1:0]     r_drain_idx;
  logic [LANE_W-1:0]    r_issue_lane;
  logic [LANE_W-1:0]    r_drain_lane;
  logic [NUM_LANES-1:0] r_busy;

  logic                 w_run;
  logic                 w_accept;
  logic [BLOCKS_W-1:0]  w_blocks_eff;
  logic                 w_issue_ok;
  logic [NUM_LANES-1:0] w_lane_v;
  logic [NUM_LANES-1:0] w_issue_oh;
  logic                 w_issue_fire;
  logic [NUM_LANES-1:0] w_collect_oh;
  logic                 w_collect;
  logic                 w_drain_last;
  logic                 w_last_collect;
  logic [HASH_W-1:0]    w_drain_hash;
  logic                 w_ser_ready;
  logic                 w_final_yumi;

  assign w_run        = (r_state == RUN);
  assign w_accept     = req_v_i & r_req_ready;
  assign w_blocks_eff = (blocks_i == '0) ? BLOCKS_W'(1) : blocks_i;
  assign w_issue_ok   = w_run & (r_issue_idx <= r_total);
  assign w_drain_last = (r_drain_idx == r_total);

  // Issue and collect both look at the registered busy flags, so a lane
  // collected this cycle is reissued one cycle later at the earliest.
  always_comb begin
    w_lane_v     = '0;
    w_collect_oh = '0;
    w_drain_hash = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      w_lane_v[l]     = w_issue_ok & (r_issue_lane == LANE_W'(l)) & ~r_busy[l];
      w_collect_oh[l] = w_run & (r_drain_lane == LANE_W'(l)) & lane_done_v_i[l]
                        & r_busy[l] & w_ser_ready;
      if (r_drain_lane == LANE_W'(l)) begin
        w_drain_hash = lane_hash_i[l*HASH_W +: HASH_W];
      end
    end
  end

  assign w_issue_oh     = w_lane_v & lane_ready_i;
  assign w_issue_fire   = |w_issue_oh;
  assign w_collect      = |w_collect_oh;
  assign w_last_collect = w_collect & w_drain_last;
  assign w_final_yumi   = last_o & yumi_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_total      <= '0;
      r_issue_idx  <= IDX_W'(1);
      r_drain_idx  <= IDX_W'(1);
      r_issue_lane <= '0;
      r_drain_lane <= '0;
      r_busy       <= '0;
    end else begin
      r_busy <= (r_busy | w_issue_oh) & ~w_collect_oh;
      if (w_issue_fire) begin
        r_issue_idx  <= r_issue_idx + IDX_W'(1);
        r_issue_lane <= (r_issue_lane == LAST_LANE) ? '0 : r_issue_lane + 1'b1;
      end
      if (w_collect) begin
        r_drain_idx  <= r_drain_idx + IDX_W'(1);
        r_drain_lane <= (r_drain_lane == LAST_LANE) ? '0 : r_drain_lane + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state      <= RUN;
            r_req_ready  <= 1'b0;
            r_total      <= IDX_W'(w_blocks_eff);
            r_issue_idx  <= IDX_W'(1);
            r_drain_idx  <= IDX_W'(1);
            r_issue_lane <= '0;
            r_drain_lane <= '0;
            r_busy       <= '0;
          end
        end
        RUN: begin
          if (w_last_collect) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (w_final_yumi) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  kda_sched_serializer #(
    .HASH_W (HASH_W),
    .DATA_W (DATA_W)
  ) u_ser (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .load_v_i     (w_collect),
    .load_hash_i  (w_drain_hash),
    .load_last_i  (w_drain_last),
    .load_ready_o (w_ser_ready),
    .data_o       (data_o),
    .v_o          (v_o),
    .last_o       (last_o),
    .yumi_i       (yumi_i)
  );

  assign req_ready_o = r_req_ready;
  assign lane_v_o    = w_lane_v;
  assign lane_yumi_o = w_collect_oh;
  assign lane_idx_o  = {NUM_LANES{r_issue_idx[BLOCKS_W-1:0]}};

`ifdef KDA_SCHED_PERF_EN
  logic [31:0] r_cycles;

  // Cleared on accept, saturating count of RUN/FLUSH cycles, held in IDLE.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cycles <= '0;
    end else if (w_accept) begin
      r_cycles <= '0;
    end else if ((r_state != IDLE) && (r_cycles != 32'hFFFF_FFFF)) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign cycles_o = r_cycles;
`else
  assign cycles_o = 32'd0;
`endif

endmodule

// File: doc/kda_sched.md
Name: kda_sched

Overview:
- Parametrised job scheduler for the KDA top level. It replaces the fixed four-chunk, single-round fan-out.
- Takes one derived-key request of 1..2^BLOCKS_W-1 hash blocks and issues PBKDF2 block indices 1..N to NUM_LANES pbkdf2 lanes in rounds.
- Collects lane hashes strictly in block order and serialises them onto a DATA_W valid/yumi output stream.
- Password, salt and iteration fields fan out to the lanes outside this block; only the block index and the handshakes pass through it.

Parameters:
- NUM_LANES, 4: number of pbkdf2 lanes, 1..8.
- BLOCKS_W, 4: width of the block count and block index.
- DATA_W, 64: output word width; HASH_W must be a multiple of it.
- HASH_W, 256: width of one lane result.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- req_v_i  in  1  request valid.
- req_ready_o  out  1  high only in IDLE.
- blocks_i  in  BLOCKS_W  requested block count; 0 is treated as 1.
- lane_v_o  out  NUM_LANES  per-lane issue valid.
- lane_ready_i  in  NUM_LANES  per-lane input ready.
- lane_idx_o  out  NUM_LANES*BLOCKS_W  block index for each lane; lane l uses slice [l*BLOCKS_W +: BLOCKS_W].
- lane_done_v_i  in  NUM_LANES  per-lane result valid.
- lane_hash_i  in  NUM_LANES*HASH_W  per-lane result.
- lane_yumi_o  out  NUM_LANES  result consumed.
- data_o  out  DATA_W  output word.
- v_o  out  1  output valid.
- last_o  out  1  final word of the job.
- yumi_i  in  1  downstream consumed the word.
- cycles_o  out  32  job cycle count (see Optional Feature).

Behaviour:
- Reset values: state IDLE; all busy flags 0; issue_idx=1, drain_idx=1; issue_lane=0, drain_lane=0.
  - Outputs: v_o=0, last_o=0, data_o=0, lane_v_o=0, lane_yumi_o=0, req_ready_o=1, cycles_o=0.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - req_v_i & req_ready_o latches total = max(blocks_i,1), then goes to RUN.
- RUN, issue side:
  - lane_v_o[l] = (l==issue_lane) & !busy[l] & (issue_idx<=total).
  - lane_idx_o carries issue_idx on every lane slice.
  - Issue fires on lane_v_o & lane_ready_i: set busy[l], issue_idx+1, issue_lane wraps modulo NUM_LANES.
  - Block k is therefore always issued to lane (k-1) mod NUM_LANES.
- RUN, collect side:
  - lane_yumi_o[drain_lane] = lane_done_v_i[drain_lane] & busy[drain_lane] & serializer-empty-or-draining.
  - Serializer-empty-or-draining means v_o==0, or the final word of the current hash is being yumi'd this cycle.
  - Collect captures lane_hash_i into the serializer, clears busy, increments drain_idx and advances drain_lane.
  - lane_done_v_i on any other lane, or on a non-busy lane, is ignored and never yumi'd.
- RUN exit: after collecting drain_idx==total, go to FLUSH.
- FLUSH: wait for the final word's yumi, then return to IDLE.
- Same-cycle collect and issue on one lane: the issue check uses registered busy, so the lane is reissued one cycle later at the earliest.
- Serializer timing:
  - v_o rises the cycle after collect.
  - Emits HASH_W/DATA_W words per block, most significant word first.
  - data_o holds stable until yumi_i; yumi_i while v_o=0 is ignored.
  - last_o=1 only on the final word of block total.
- Back-to-back blocks: the next hash loads on the same edge the previous final word is yumi'd, so there is no bubble.
- Latency: request accept to first lane_v_o is 1 cycle.
- Widths: issue_idx and drain_idx are BLOCKS_W+1 bits wide so that total+1 does not wrap.
- Mid-job reset discards all state; lanes share reset_i.

Optional Feature:
- Macro: KDA_SCHED_PERF_EN.
- Defined: cycles_o clears on request accept, increments every cycle in RUN or FLUSH, and saturates at 0xFFFFFFFF. It holds its value in IDLE until the next accept.
- Undefined: cycles_o is tied to 0 and no counter is built.

Decomposition:
- kda_pkg holds:
  - state enum kda_sched_state_e {IDLE, RUN, FLUSH};
  - localparam KDA_HASH_W=256;
  - localparam KDA_DATA_W=64;
  - function words_per_hash(HASH_W, DATA_W).
- One sub-module, kda_sched_serializer:
  - HASH_W load port, load-accept signal, word counter;
  - outputs data_o, v_o, last_o, yumi_i, plus an empty_or_draining status.
- Lane selection and busy bookkeeping stay in kda_sched.

Test Plan:
- NUM_LANES=4, blocks_i=1, lane 0 returns 256'h00..01 after 10 cycles:
  - only lane_v_o[0] fires, with lane_idx 1;
  - 4 words come out, MSW first; last_o on word 4;
  - req_ready_o returns high after that yumi.
- blocks_i=6:
  - lanes 0..3 receive idx 1..4; lanes 0,1 receive idx 5,6 only after their first collects;
  - output blocks appear in order 1..6; 24 words; one last_o.
- Lanes finish in reverse order (lane 3 first):
  - lane_yumi_o[3] stays low until lanes 0..2 have been collected;
  - output order is unchanged.
- Downstream stalls (yumi_i low 20 cycles) while lane 1 is done:
  - lane_yumi_o[1] is withheld;
  - data_o is stable;
  - no word is lost or duplicated.
- blocks_i=0:
  - behaves as blocks_i=1.
- reset_i during block 3 of 6, then a new request with blocks_i=2:
  - outputs return to their reset values;
  - the new job issues idx 1,2 to lanes 0,1.
  - With KDA_SCHED_PERF_EN: cycles_o equals accept-to-final-yumi cycles.
